// File: rtl/kyber_loader_pkg.sv
// ============================================================================
// Module   : kyber_loader_pkg
// Brief    : Shared states, register offsets and constants for the noise loader
// Revision : 1.0
// ============================================================================
`default_nettype none

package kyber_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MSG   = 3'd2,
        ST_WRITE = 3'd3,
        ST_TRIG  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [31:0] c_off_key_coef = 32'h0000_0040;
    localparam logic [31:0] c_off_msg      = 32'h0000_0080;
    localparam logic [31:0] c_off_enc_coef = 32'h0000_0084;
    localparam logic [31:0] c_off_key_trig = 32'h0000_0164;
    localparam logic [31:0] c_off_enc_trig = 32'h0000_0168;

    localparam int unsigned c_n_key_coef = 16;
    localparam int unsigned c_n_enc_coef = 20;
    localparam int unsigned c_q          = 17;

endpackage

`default_nettype wire

// File: rtl/cbd1_sampler.sv
// ============================================================================
// Module   : cbd1_sampler
// Brief    : Centered-binomial (eta=1) sample of two random bits, mod Q
// Revision : 1.0
// ============================================================================
`default_nettype none

module cbd1_sampler #(
    parameter int unsigned Q = 17
) (
    input  logic [1:0] i_bits,
    output logic [4:0] o_coef
);

    // a = bit 0, b = bit 1; a-b of -1 is folded to Q-1
    always_comb begin
        o_coef = 5'd0;
        if (i_bits == 2'b01)
            o_coef = 5'd1;
        else if (i_bits == 2'b10)
            o_coef = 5'(Q - 1);
    end

endmodule

`default_nettype wire

// File: rtl/kyber_noise_loader.sv
// ============================================================================
// Module   : kyber_noise_loader
// Brief    : Expands random words into eta=1 noise and loads the Kyber core
// Revision : 1.0
// ============================================================================
`default_nettype none

module kyber_noise_loader
    import kyber_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_7000,
    parameter int unsigned Q         = c_q
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] message,
    input  logic        rnd_valid,
    output logic        rnd_ready,
    input  logic [31:0] rnd_data,
    output logic        enable,
    output logic [31:0] addr_Req,
    output logic [31:0] data_Req,
    output logic        wen_Req,
    output logic [7:0]  bytelane_Req,
    output logic        busy,
    output logic        done
);

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_bit_idx, w_bit_idx_nxt;
    logic [31:0] r_shift, w_shift_nxt;
    logic        r_mode, w_mode_nxt;
    logic [31:0] r_msg, w_msg_nxt;

    logic        w_enable_nxt, w_wen_nxt, w_done_nxt;
    logic [31:0] w_addr_nxt, w_data_nxt;
    logic [4:0]  w_coef, w_last;

    // Samples the coefficient that will be on the bus next cycle
    cbd1_sampler #(.Q(Q)) u_sampler (
        .i_bits (w_shift_nxt[1:0]),
        .o_coef (w_coef)
    );

    assign w_last    = r_mode ? 5'(c_n_enc_coef - 1) : 5'(c_n_key_coef - 1);
    assign rnd_ready = (r_state == ST_FETCH);
    assign busy      = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_mode_nxt    = r_mode;
        w_msg_nxt     = r_msg;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_mode_nxt    = mode;
                    w_msg_nxt     = message;
                    w_cnt_nxt     = 5'd0;
                    w_bit_idx_nxt = 4'd0;
                    w_state_nxt   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (rnd_valid) begin
                    w_shift_nxt   = rnd_data;
                    w_bit_idx_nxt = 4'd0;
                    w_state_nxt   = (r_mode && r_cnt == 5'd0) ? ST_MSG : ST_WRITE;
                end
            end
            ST_MSG:   w_state_nxt = ST_WRITE;
            ST_WRITE: begin
                w_cnt_nxt     = r_cnt + 5'd1;
                w_shift_nxt   = {2'b00, r_shift[31:2]};
                w_bit_idx_nxt = (r_bit_idx == 4'hF) ? r_bit_idx : r_bit_idx + 4'd1;
                if (r_cnt == w_last)
                    w_state_nxt = ST_TRIG;
                else if (r_bit_idx == 4'hF)
                    w_state_nxt = ST_FETCH;
            end
            ST_TRIG:  w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus values are derived from the next state so the outputs are registered
    always_comb begin
        w_enable_nxt = (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_MSG) ||
                       (w_state_nxt == ST_WRITE) || (w_state_nxt == ST_TRIG);
        w_wen_nxt    = 1'b0;
        w_addr_nxt   = 32'd0;
        w_data_nxt   = 32'd0;
        w_done_nxt   = (w_state_nxt == ST_DONE);
        case (w_state_nxt)
            ST_MSG: begin
                w_wen_nxt  = 1'b1;
                w_addr_nxt = BASE_ADDR + c_off_msg;
                w_data_nxt = r_msg;
            end
            ST_WRITE: begin
                w_wen_nxt  = 1'b1;
                w_addr_nxt = BASE_ADDR + (r_mode ? c_off_enc_coef : c_off_key_coef) +
                             {25'd0, w_cnt_nxt, 2'b00};
                w_data_nxt = {27'd0, w_coef};
            end
            ST_TRIG: begin
                w_wen_nxt  = 1'b1;
                w_addr_nxt = BASE_ADDR + (r_mode ? c_off_enc_trig : c_off_key_trig);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 5'd0;
            r_bit_idx    <= 4'd0;
            r_shift      <= 32'd0;
            r_mode       <= 1'b0;
            r_msg        <= 32'd0;
            enable       <= 1'b0;
            wen_Req      <= 1'b0;
            addr_Req     <= 32'd0;
            data_Req     <= 32'd0;
            bytelane_Req <= 8'h00;
            done         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_mode       <= w_mode_nxt;
            r_msg        <= w_msg_nxt;
            enable       <= w_enable_nxt;
            wen_Req      <= w_wen_nxt;
            addr_Req     <= w_addr_nxt;
            data_Req     <= w_data_nxt;
            bytelane_Req <= w_wen_nxt ? 8'hFF : 8'h00;
            done         <= w_done_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_kyber_noise_loader.sv
// ============================================================================
// Module   : tb_kyber_noise_loader
// Brief    : Scoreboard bench for kyber_noise_loader bus write sequences
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_kyber_noise_loader;

    localparam logic [31:0] BASE = 32'h4000_7000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] message;
    logic        rnd_valid;
    logic        rnd_ready;
    logic [31:0] rnd_data;
    logic        enable;
    logic [31:0] addr_Req;
    logic [31:0] data_Req;
    logic        wen_Req;
    logic [7:0]  bytelane_Req;
    logic        busy;
    logic        done;

    kyber_noise_loader #(.BASE_ADDR(BASE), .Q(17)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .message      (message),
        .rnd_valid    (rnd_valid),
        .rnd_ready    (rnd_ready),
        .rnd_data     (rnd_data),
        .enable       (enable),
        .addr_Req     (addr_Req),
        .data_Req     (data_Req),
        .wen_Req      (wen_Req),
        .bytelane_Req (bytelane_Req),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    int          done_q[$];
    logic [31:0] feed_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          t0    = 0;
    logic        hs_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Random-word feeder: advance to the next word after each handshake
    always @(negedge clk) hs_seen = rnd_valid && rnd_ready;
    always @(posedge clk) begin
        #1;
        if (hs_seen && feed_q.size() > 0) begin
            void'(feed_q.pop_front());
            rnd_data = (feed_q.size() > 0) ? feed_q[0] : 32'd0;
        end
    end

    // Monitor: compares every bus write and done pulse against the scoreboard
    always @(negedge clk) begin
        wr_t e;
        int  dc;
        if (!rst) begin
            if (wen_Req) begin
                tests++;
                if (wr_q.size() == 0) begin
                    fails++;
                    $display("FAIL write_unexpected: got addr=%h data=%h cycle=%0d, expected no write",
                             addr_Req, data_Req, cyc);
                end else begin
                    e = wr_q.pop_front();
                    if (cyc != e.cyc || addr_Req !== e.addr || data_Req !== e.data ||
                        bytelane_Req !== 8'hFF || enable !== 1'b1) begin
                        fails++;
                        $display("FAIL write: got cyc=%0d addr=%h data=%h be=%h en=%b, expected cyc=%0d addr=%h data=%h be=ff en=1",
                                 cyc, addr_Req, data_Req, bytelane_Req, enable, e.cyc, e.addr, e.data);
                    end
                end
            end else begin
                tests++;
                if (bytelane_Req !== 8'h00) begin
                    fails++;
                    $display("FAIL idle_bytelane: got %h, expected 00", bytelane_Req);
                end
            end
            if (done) begin
                tests++;
                if (done_q.size() == 0) begin
                    fails++;
                    $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
                end else begin
                    dc = done_q.pop_front();
                    if (cyc != dc || enable !== 1'b0 || busy !== 1'b1) begin
                        fails++;
                        $display("FAIL done: got cyc=%0d en=%b busy=%b, expected cyc=%0d en=0 busy=1",
                                 cyc, enable, busy, dc);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_rnd_ready"}, {31'd0, rnd_ready}, 32'd0);
        chk({nm, "_enable"},    {31'd0, enable},    32'd0);
        chk({nm, "_wen"},       {31'd0, wen_Req},   32'd0);
        chk({nm, "_busy"},      {31'd0, busy},      32'd0);
        chk({nm, "_done"},      {31'd0, done},      32'd0);
        chk({nm, "_addr"},      addr_Req,           32'd0);
        chk({nm, "_data"},      data_Req,           32'd0);
        chk({nm, "_bytelane"},  {24'd0, bytelane_Req}, 32'd0);
    endtask

    task automatic feed(input logic [31:0] w1, input logic [31:0] w2, input int n);
        feed_q.delete();
        feed_q.push_back(w1);
        if (n > 1) feed_q.push_back(w2);
        rnd_data = w1;
    endtask

    // Mode and message are scrambled right after capture; the DUT must ignore it
    task automatic start_seq(input logic m, input logic [31:0] msg);
        @(posedge clk); #1;
        mode    = m;
        message = msg;
        start   = 1'b1;
        t0      = cyc;
        @(posedge clk); #1;
        start   = 1'b0;
        mode    = ~m;
        message = ~msg;
    endtask

    task automatic exp_wr(input int rel, input logic [31:0] off, input logic [31:0] d);
        wr_t e;
        e.cyc  = t0 + rel;
        e.addr = BASE + off;
        e.data = d;
        wr_q.push_back(e);
    endtask

    task automatic push_mode0(input int sh, input logic [31:0] c0, input logic [31:0] c1,
                              input logic [31:0] rest);
        for (int k = 0; k < 16; k++)
            exp_wr(2 + sh + k, 32'h40 + 32'(4 * k), (k == 0) ? c0 : (k == 1) ? c1 : rest);
        exp_wr(18 + sh, 32'h164, 32'd0);
        done_q.push_back(t0 + 19 + sh);
    endtask

    task automatic wait_done(input string nm, input int limit);
        int n = 0;
        while (done_q.size() > 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({nm, "_done_pending"}, done_q.size(), 32'd0);
        chk({nm, "_writes_pending"}, wr_q.size(), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        message   = 32'd0;
        rnd_valid = 1'b1;
        rnd_data  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Mode 0 with uniform words
        feed(32'h0000_0000, 32'd0, 1);
        start_seq(1'b0, 32'd0);
        push_mode0(0, 32'd0, 32'd0, 32'd0);
        wait_done("m0_zero", 60);

        feed(32'h5555_5555, 32'd0, 1);
        start_seq(1'b0, 32'd0);
        push_mode0(0, 32'd1, 32'd1, 32'd1);
        wait_done("m0_5555", 60);

        feed(32'hAAAA_AAAA, 32'd0, 1);
        start_seq(1'b0, 32'd0);
        push_mode0(0, 32'd16, 32'd16, 32'd16);
        wait_done("m0_aaaa", 60);

        // Mode 1: message, 16 coefficients, second fetch, 4 coefficients, trigger
        feed(32'h0000_00F9, 32'h0000_0006, 2);
        start_seq(1'b1, 32'h0000_000B);
        exp_wr(2, 32'h80, 32'h0000_000B);
        for (int k = 0; k < 16; k++)
            exp_wr(3 + k, 32'h84 + 32'(4 * k), (k == 0) ? 32'd1 : (k == 1) ? 32'd16 : 32'd0);
        for (int k = 16; k < 20; k++)
            exp_wr(20 + k - 16, 32'h84 + 32'(4 * k), (k == 16) ? 32'd16 : (k == 17) ? 32'd1 : 32'd0);
        exp_wr(24, 32'h168, 32'd0);
        done_q.push_back(t0 + 25);
        wait_done("m1", 80);

        // Stall in the first fetch for 5 cycles
        rnd_valid = 1'b0;
        feed(32'h0000_0009, 32'd0, 1);
        start_seq(1'b0, 32'd0);
        push_mode0(5, 32'd1, 32'd16, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rnd_ready", {31'd0, rnd_ready}, 32'd1);
            chk("stall_wen", {31'd0, wen_Req}, 32'd0);
            @(posedge clk); #1;
        end
        rnd_valid = 1'b1;
        wait_done("stall", 60);

        // Start re-pulsed mid-sequence with a different mode
        feed(32'hAAAA_AAAA, 32'd0, 1);
        start_seq(1'b0, 32'd0);
        push_mode0(0, 32'd16, 32'd16, 32'd16);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        mode  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("repulse", 60);

        // Reset in the middle of the write burst
        feed(32'h5555_5555, 32'd0, 1);
        start_seq(1'b0, 32'd0);
        for (int k = 0; k < 6; k++)
            exp_wr(2 + k, 32'h40 + 32'(4 * k), 32'd1);
        repeat (7) @(posedge clk);
        #1;
        chk("midrst_pre_wen", {31'd0, wen_Req}, 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        feed_q.delete();
        repeat (25) @(posedge clk);
        #1;
        chk("midrst_writes_pending", wr_q.size(), 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);

        feed(32'h5555_5555, 32'd0, 1);
        start_seq(1'b0, 32'd0);
        push_mode0(0, 32'd1, 32'd1, 32'd1);
        wait_done("post_rst", 60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/kyber_noise_loader.md
# kyber_noise_loader

Upstream feeder for the Baby Kyber accelerator register interface. It draws 32-bit random words and expands them into centered-binomial (eta = 1) noise coefficients in {-1, 0, 1}, stored mod 17 as {16, 0, 1}. It then issues the memory-mapped writes that load s/e (key generation) or message/r/e1/e2 (encryption) into the accelerator, and finishes with the matching trigger write. Its bus outputs drive the accelerator's `enable`/`addr_Req`/`data_Req`/`wen_Req`/`bytelane_Req` inputs directly.

## Interface
- `BASE_ADDR`, default 32'h4000_7000: accelerator register base.
- `Q`, default 17: modulus; -1 is encoded as Q-1.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst` in, 1: reset, asynchronous, active-high.
- `start` in, 1: one-cycle request; sampled only in IDLE.
- `mode` in, 1: 0 = key-generation load, 1 = encryption load; captured with `start`.
- `message` in, 32: encryption message; captured with `start`.
- `rnd_valid` in, 1 / `rnd_ready` out, 1 / `rnd_data` in, 32: random-word valid/ready handshake.
- `enable` out, 1; `addr_Req` out, 32; `data_Req` out, 32; `wen_Req` out, 1; `bytelane_Req` out, 8: accelerator bus.
- `busy` out, 1: high in every state except IDLE.
- `done` out, 1: one-cycle pulse when the sequence completes.

## Operation
- States:
  - IDLE -> FETCH on `start`.
  - FETCH -> MSG (mode 1, first word only) or WRITE, on handshake.
  - MSG -> WRITE.
  - WRITE -> FETCH (mode 1, after coefficient 15) or TRIG (after the last coefficient).
  - TRIG -> DONE.
  - DONE -> IDLE.
- FETCH: `rnd_ready`=1. A handshake is `rnd_valid & rnd_ready` at the clock edge; the word is latched into a 32-bit shift register.
- Coefficient k of the current word uses a = bit[2k] and b = bit[2k+1]:
  - a-b = 1 gives 1.
  - a-b = -1 gives Q-1.
  - a-b = 0 gives 0.
  - `data_Req` is the 5-bit result zero-extended to 32 bits.
- Mode 0: 16 coefficients from one word, written to BASE+0x40+4k (k = 0..15; s then e), followed by the trigger write to BASE+0x164.
- Mode 1:
  - MSG writes `message` to BASE+0x80.
  - Coefficients k = 0..19 are written to BASE+0x84+4k (r, e1, e2).
  - k = 0..15 come from word 1, k = 16..19 from bits [7:0] of word 2; bits [31:8] of word 2 are discarded.
  - The trigger write goes to BASE+0x168.
- Trigger writes carry data 0.
- `start` while `busy` is ignored. `mode` and `message` changes after capture are ignored.
- All arithmetic is unsigned. The coefficient counter is 5 bits, the word-bit index is 4 bits, and neither wraps within a sequence.

## Timing
- Reset values: `rnd_ready`, `enable`, `wen_Req`, `busy`, `done` = 0; `addr_Req`, `data_Req` = 0; `bytelane_Req` = 8'h00; state = IDLE; counters = 0.
- All bus outputs are registered. Each write occupies exactly one cycle with `wen_Req`=1 and `bytelane_Req`=8'hFF; in every other cycle `wen_Req`=0 and `bytelane_Req`=8'h00.
- `enable`=1 from the cycle after `start` through the TRIG cycle inclusive, including a second FETCH. It is 0 in IDLE and DONE.
- Mode 0, with `rnd_valid` held high and `start` at cycle 0:
  - FETCH at cycle 1.
  - Writes at cycles 2-17.
  - Trigger at cycle 18.
  - `done` at cycle 19.
- Mode 1, same conditions:
  - FETCH at cycle 1.
  - MSG at cycle 2.
  - Writes at cycles 3-18.
  - FETCH at cycle 19.
  - Writes at cycles 20-23.
  - Trigger at cycle 24.
  - `done` at cycle 25.
- `rnd_valid` low in FETCH stalls the sequence. No writes occur during the stall, `enable` stays as defined, and there is no timeout.
- `rst` mid-sequence returns to reset values immediately and asynchronously. Accelerator registers already written are not restored, and no trigger is issued.

## Structure
- Package `kyber_loader_pkg` holds:
  - The state enum.
  - Register offsets: 0x40, 0x80, 0x84, 0x164, 0x168.
  - Coefficient counts: 16 and 20.
  - `Q`.
- Sub-module `cbd1_sampler` is purely combinational: 2 random bits in, 5-bit mod-Q coefficient out.

## Test plan
- Mode 0, word 0x0000_0000 -> 16 writes of 0 to 0x4000_7040..0x4000_707C, then 0 to 0x4000_7164; `done` at cycle 19.
- Mode 0, word 0x5555_5555 -> all 16 coefficients = 1. Word 0xAAAA_AAAA -> all 16 = 0x10 (16).
- Mode 1, `message`=0xB, words 0x0000_00F9 then 0x0000_0006 -> writes in this order:
  - 0xB to 0x80.
  - 1, 16, 0, 0 to 0x84..0x90.
  - 0 to 0x94..0xC0.
  - 16, 1, 0, 0 to 0xC4..0xD0.
  - Trigger 0 to 0x168; `done` at cycle 25.
- `rnd_valid` held low for 5 cycles in the first FETCH -> `rnd_ready`=1 and `wen_Req`=0 throughout; the sequence resumes and all later events shift by 5 cycles.
- `start` re-pulsed mid-sequence -> ignored, write count unchanged. `rst` at mid-WRITE cycle 8 -> all outputs at reset values the same cycle, no trigger, and a new `start` works normally.
